// File: rtl/lc3_bus_arbiter.sv
// lc3_bus_arbiter
// Round-robin owner of the LC-3 shared data bus. Grants one tri-state source
// at a time, inserts TURNAROUND dead cycles between owners and pre-empts an
// owner that has held the bus for MAX_HOLD cycles while someone else waits.
//
// Parameters:
//   NREQ        number of bus sources (2..8), default map 0=PC 1=MARMUX 2=ALU 3=MDR
//   TURNAROUND  idle cycles with all gates low between owners (0..3)
//   MAX_HOLD    gate-high cycles before a contested owner is released (2..255)
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       per-source level request, held until done
//   last      per-source final-cycle flag, only looked at for the owner
//   gate      registered one-hot (or zero) gate enables
//   owner     index of the current / most recent owner
//   bus_busy  registered copy of |gate
//   preempt   one-cycle pulse after a forced release
module lc3_bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           last,
  output logic [NREQ-1:0]           gate,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      bus_busy,
  output logic                      preempt
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0]     NREQ_W    = (IW+1)'(NREQ);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NREQ - 1);
  localparam logic [7:0]      HOLD_LIM  = 8'(MAX_HOLD - 1);
  localparam logic [1:0]      TURN_INIT = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;
  localparam logic [NREQ-1:0] ONE       = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [7:0]      hold_cnt, hold_nxt;
  logic [1:0]      turn_cnt, turn_nxt;
  logic [NREQ-1:0] gate_nxt;
  logic [IW-1:0]   owner_nxt;
  logic            preempt_nxt;

  logic [NREQ-1:0] own_oh, others;
  logic            norm_rel, pre_rel;

  logic [NREQ-1:0] arb_req, arb_rot;
  logic [IW-1:0]   arb_off, arb_idx, arb_next;
  logic [IW:0]     arb_sum;
  logic            arb_found;
  logic            do_arb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate     <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      preempt  <= 1'b0;
      bus_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      gate     <= gate_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
      preempt  <= preempt_nxt;
      bus_busy <= |gate_nxt;
    end
  end

  // Release conditions for the current owner. Only the owner's bits of
  // req/last matter while granted.
  always_comb begin
    own_oh   = ONE << owner;
    others   = req & ~own_oh;
    norm_rel = (|(last & own_oh)) || !(|(req & own_oh));
    pre_rel  = (hold_cnt == HOLD_LIM) && (|others);
  end

  // The only arbitration that happens from GRANT is the zero-turnaround
  // handover, which must skip the releasing owner.
  always_comb begin
    arb_req = (state == GRANT) ? others : req;
  end

  // Rotate requests so that bit 0 is the ptr position, take the lowest set
  // bit, then rotate the offset back into a source index.
  always_comb begin
    arb_rot   = NREQ'({arb_req, arb_req} >> ptr);
    arb_found = 1'b0;
    arb_off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (arb_rot[i]) begin
        arb_found = 1'b1;
        arb_off   = IW'(i);
      end
    end
    arb_sum = {1'b0, ptr} + {1'b0, arb_off};
    if (arb_sum >= NREQ_W) arb_sum = arb_sum - NREQ_W;
    arb_idx  = arb_sum[IW-1:0];
    arb_next = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
  end

  always_comb begin
    state_nxt   = state;
    gate_nxt    = gate;
    owner_nxt   = owner;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    turn_nxt    = turn_cnt;
    preempt_nxt = 1'b0;
    do_arb      = 1'b0;

    case (state)
      IDLE: do_arb = 1'b1;
      GRANT: begin
        if (norm_rel || pre_rel) begin
          gate_nxt    = '0;
          // A normal release wins over a coincident pre-emption.
          preempt_nxt = pre_rel && !norm_rel;
          if (TURNAROUND > 0) begin
            state_nxt = TURN;
            turn_nxt  = TURN_INIT;
          end else begin
            do_arb = 1'b1;
          end
        end else if (hold_cnt != 8'hFF) begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      TURN: begin
        if (turn_cnt == 2'd0) do_arb = 1'b1;
        else                  turn_nxt = turn_cnt - 2'd1;
      end
      default: state_nxt = IDLE;
    endcase

    if (do_arb) begin
      if (arb_found) begin
        state_nxt = GRANT;
        gate_nxt  = ONE << arb_idx;
        owner_nxt = arb_idx;
        ptr_nxt   = arb_next;
        hold_nxt  = '0;
      end else begin
        state_nxt = IDLE;
        gate_nxt  = '0;
      end
    end
  end

endmodule

// File: tb/tb_lc3_bus_arbiter.sv
// tb_lc3_bus_arbiter
// Self-checking bench for lc3_bus_arbiter. Two instances share clock and
// reset: dut_a uses TURNAROUND=1, dut_b uses TURNAROUND=0. Only the selected
// instance receives requests; its outputs are compared every cycle against
// a reference model that tracks "who owns the bus, for how many cycles, and
// how many dead cycles remain" directly from the arbitration rules.
module tb_lc3_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_a, last_a, req_b, last_b;
  logic [3:0] gate_a, gate_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, busy_b, pre_a, pre_b;
  logic       sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_cur;
  int m_owner;
  int m_ptr;
  int m_held;
  int m_gap;
  bit m_pre;

  always #5 clk = ~clk;

  lc3_bus_arbiter #(.NREQ(4), .TURNAROUND(1), .MAX_HOLD(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .last(last_a),
    .gate(gate_a), .owner(owner_a), .bus_busy(busy_a), .preempt(pre_a)
  );

  lc3_bus_arbiter #(.NREQ(4), .TURNAROUND(0), .MAX_HOLD(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .last(last_b),
    .gate(gate_b), .owner(owner_b), .bus_busy(busy_b), .preempt(pre_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: observed %0h required %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
    if (sel) begin
      req_b = r; last_b = l; req_a = '0; last_a = '0;
    end else begin
      req_a = r; last_a = l; req_b = '0; last_b = '0;
    end
  endtask

  function automatic bit has(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  function automatic int pick(input logic [3:0] r);
    for (int i = 0; i < NREQ; i++)
      if (has(r, (m_ptr + i) % NREQ)) return (m_ptr + i) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_cur = -1; m_owner = 0; m_ptr = 0; m_held = 0; m_gap = 0; m_pre = 1'b0;
  endtask

  task automatic model_grant(input int w);
    if (w >= 0) begin
      m_cur   = w;
      m_owner = w;
      m_ptr   = (w + 1) % NREQ;
      m_held  = 1;
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l, input int ta);
    bit         norm, contested;
    logic [3:0] mask;
    m_pre = 1'b0;
    if (m_cur >= 0) begin
      mask      = 4'b0001 << m_cur;
      norm      = has(l, m_cur) || !has(r, m_cur);
      contested = (m_held == MAX_HOLD) && ((r & ~mask) != 4'b0000);
      if (norm || contested) begin
        m_pre = contested && !norm;
        m_cur = -1;
        if (ta > 0) m_gap = ta;
        else        model_grant(pick(r & ~mask));
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) model_grant(pick(r));
    end else begin
      model_grant(pick(r));
    end
  endtask

  task automatic compare_all();
    logic [3:0] exp_gate;
    exp_gate = (m_cur >= 0) ? (4'b0001 << m_cur) : 4'b0000;
    checkOutput("gate",     32'(sel ? gate_b  : gate_a),  32'(exp_gate));
    checkOutput("owner",    32'(sel ? owner_b : owner_a), 32'(m_owner));
    checkOutput("bus_busy", 32'(sel ? busy_b  : busy_a),  32'(m_cur >= 0));
    checkOutput("preempt",  32'(sel ? pre_b   : pre_a),   32'(m_pre));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(sel ? req_b : req_a, sel ? last_b : last_a, sel ? 0 : 1);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int cycles, input int last_div);
    logic [3:0] r, l;
    r = 4'($urandom_range(15));
    for (int n = 0; n < cycles; n++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(7) == 0) r = r ^ (4'b0001 << b);
      l = '0;
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(last_div - 1) == 0) l = l | (4'b0001 << b);
      applyStimulus(r, l);
      cycle();
    end
  endtask

  initial begin
    logic [3:0] gate_prev, g_old, first_other;
    int         order[$];
    int         exp_order[5];
    int         cnt_gate, cnt_pre;

    sel = 1'b0;
    rst_n = 1'b0;
    req_a = '0; last_a = '0; req_b = '0; last_b = '0;
    model_reset();

    // Reset held with all requests up: nothing may be granted.
    applyStimulus(4'b1111, 4'b0000);
    cycle();
    cycle();
    checkOutput("reset_gate", 32'(gate_a), 32'd0);
    checkOutput("reset_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    applyStimulus(4'b0101, 4'b0000);
    cycle();
    checkOutput("first_grant_gate",  32'(gate_a),  32'h1);
    checkOutput("first_grant_owner", 32'(owner_a), 32'd0);

    // Round robin: every owner ends on its second cycle.
    do_reset();
    applyStimulus(4'b1111, 4'b0000);
    gate_prev = '0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(4'b1111, (gate_a != 4'b0 && gate_a == gate_prev) ? gate_a : 4'b0000);
      g_old = gate_a;
      cycle();
      if (g_old == 4'b0 && gate_a != 4'b0) order.push_back(int'(owner_a));
      gate_prev = g_old;
    end
    exp_order = '{0, 1, 2, 3, 0};
    checkOutput("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      checkOutput("rr_order", 32'(order[i]), 32'(exp_order[i]));

    // Contested pre-emption of owner 2 by source 3.
    do_reset();
    applyStimulus(4'b0100, 4'b0000);
    cycle();
    cnt_gate = (gate_a == 4'b0100) ? 1 : 0;
    cnt_pre = 0;
    first_other = '0;
    applyStimulus(4'b1100, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (gate_a == 4'b0100) cnt_gate++;
      if (pre_a) cnt_pre++;
      if (gate_a != 4'b0 && gate_a != 4'b0100 && first_other == 4'b0) first_other = gate_a;
    end
    checkOutput("preempt_hold_cycles", 32'(cnt_gate), 32'd16);
    checkOutput("preempt_pulses",      32'(cnt_pre),  32'd1);
    checkOutput("preempt_next_owner",  32'(first_other), 32'h8);

    // Uncontested owner keeps the bus.
    do_reset();
    applyStimulus(4'b0100, 4'b0000);
    cnt_pre = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (pre_a) cnt_pre++;
    end
    checkOutput("uncontested_pulses", 32'(cnt_pre), 32'd0);
    checkOutput("uncontested_gate",   32'(gate_a),  32'h4);

    // last[1] coincides with the pre-emption edge: normal release.
    do_reset();
    applyStimulus(4'b0010, 4'b0000);
    cycle();
    applyStimulus(4'b0011, 4'b0000);
    for (int i = 0; i < 15; i++) cycle();
    applyStimulus(4'b0011, 4'b0010);
    cycle();
    checkOutput("coincide_preempt", 32'(pre_a),  32'd0);
    checkOutput("coincide_gate",    32'(gate_a), 32'd0);

    // Zero turnaround: abandoned grant hands over on a single edge.
    sel = 1'b1;
    do_reset();
    applyStimulus(4'b0001, 4'b0000);
    cycle();
    applyStimulus(4'b0011, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput("abandon_hold", 32'(gate_b), 32'h1);
    end
    applyStimulus(4'b0010, 4'b0000);
    cycle();
    checkOutput("abandon_handover", 32'(gate_b), 32'h2);
    checkOutput("abandon_owner",    32'(owner_b), 32'd1);

    // Asynchronous reset in the middle of a grant.
    sel = 1'b0;
    do_reset();
    applyStimulus(4'b0100, 4'b0000);
    cycle();
    checkOutput("async_pre_gate", 32'(gate_a), 32'h4);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("async_gate", 32'(gate_a), 32'd0);
    checkOutput("async_busy", 32'(busy_a), 32'd0);
    cycle();
    rst_n = 1'b1;
    applyStimulus(4'b1010, 4'b0000);
    cycle();
    checkOutput("async_regrant_gate",  32'(gate_a),  32'h2);
    checkOutput("async_regrant_owner", 32'(owner_a), 32'd1);

    // Randomised traffic on both instances.
    do_reset();
    random_phase(400, 6);
    random_phase(400, 24);
    sel = 1'b1;
    do_reset();
    random_phase(400, 6);
    random_phase(400, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
